fetch_flow_ctrl: RTL and testbench
==================================

// Module: fetch_flow_ctrl
// PURPOSE
//  Sequencing controller for the fetch/decode front end. Generates StallF/StallD/FlushD/FlushE,
//  resolves branch mispredictions from execute and drives the PC redirect, and gates predictor
//  state updates (StateUpdateEnable). Also sequences a post-reset boot hold, a halt/resume
//  handshake, and saturating mispredict/stall performance counters.
// PARAMETERS
//  BOOT_CYCLES  4   cycles fetch is held after reset release (imem warm-up); 0 = go straight to RUN
//  CNT_W        16  width of each performance counter (saturating)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   asynchronous, active-low reset (rst==0 resets)
//  Eval_branchE      in   1   conditional branch/jump is resolving in E this cycle
//  PCSrcE            in   1   actual outcome in E (1 = taken)
//  Predict_branchE   in   1   prediction carried down with the E instruction
//  PCTargetE         in   32  taken target from E
//  PCPlus4E          in   32  fall-through PC of the E instruction
//  lu_hazardD        in   1   load-use hazard detected by decode
//  halt_req          in   1   request to freeze fetch (level)
//  halt_ack          out  1   1 while in HALT state
//  StallF            out  1   hold the F/D pipeline register
//  StallD            out  1   hold the PC register
//  FlushD            out  1   clear the F/D pipeline register
//  FlushE            out  1   clear the D/E pipeline register
//  redirect_valid    out  1   force the PC mux to redirect_pc this cycle
//  redirect_pc       out  32  corrected PC
//  StateUpdateEnable out  1   predictor may update its history/counters this cycle
//  mispred_cnt       out  CNT_W  mispredictions since reset
//  stall_cnt         out  CNT_W  cycles with StallF=1 since reset
// BEHAVIOUR
//  FSM states: BOOT, RUN, HALT. Reset -> BOOT with boot counter = 0; outputs of the combinational
//   logic, counters = 0, halt_ack = 0. BOOT_CYCLES==0: reset enters RUN directly.
//  BOOT: StallF=StallD=1, FlushD=1, FlushE=1, redirect_valid=0, StateUpdateEnable=0; counter++;
//   after exactly BOOT_CYCLES cycles (counter==BOOT_CYCLES-1) -> RUN. Branch inputs are ignored.
//  mispredict = Eval_branchE & (PCSrcE != Predict_branchE); evaluated combinationally in RUN and HALT.
//  redirect_pc = PCSrcE ? PCTargetE : PCPlus4E (combinational, valid whenever redirect_valid=1).
//  RUN, priority high -> low:
//   1 mispredict: redirect_valid=1, FlushD=1, FlushE=1, StallF=StallD=0 (same cycle; 2-cycle penalty).
//   2 lu_hazardD: StallF=StallD=1, FlushE=1 (bubble), FlushD=0.
//   3 otherwise all control outputs 0.
//   Mispredict + lu_hazardD together: rule 1 only; the hazard instruction is flushed.
//  StateUpdateEnable = Eval_branchE in RUN and HALT, 0 in BOOT (updates on every resolved branch,
//   correct or not).
//  RUN -> HALT when halt_req=1 and mispredict=0 (if mispredict, the redirect completes first and
//   HALT is entered on the next cycle in which halt_req is still 1).
//  HALT: halt_ack=1; StallF=StallD=1, FlushE=1 (E drains, no new issue). A mispredict resolving in
//   HALT still asserts redirect_valid and FlushD (redirect PC captured; StallD is overridden to 0 for
//   that cycle). HALT -> RUN the cycle after halt_req drops; halt_ack deasserts on that same edge.
//  Counters: mispred_cnt += 1 on each mispredict cycle (RUN or HALT); stall_cnt += 1 on each cycle
//   with StallF=1 in RUN or HALT (BOOT not counted). Both saturate at 2^CNT_W-1, never wrap.
//  Reset mid-operation: asynchronously forces BOOT, zeroes counters, drops halt_ack and redirect.
//  All outputs besides halt_ack and counters are combinational from state + inputs; no X on outputs
//   while rst==0.
// TESTING
//  1 reset low 3 cycles, release, BOOT_CYCLES=4 -> StallF=1 for exactly 4 cycles, RUN on 5th, stall_cnt=0.
//  2 RUN, Eval_branchE=1, PCSrcE=1, Predict=0, PCTargetE=0x100 -> redirect_valid=1, redirect_pc=0x100,
//    FlushD=FlushE=1, mispred_cnt=1; PCSrcE=0, Predict=1, PCPlus4E=0x48 -> redirect_pc=0x48.
//  3 mispredict and lu_hazardD same cycle -> FlushD=FlushE=1, StallF=0; lu_hazardD alone -> StallF=StallD=1,
//    FlushE=1, FlushD=0.
//  4 halt_req=1 for 5 cycles -> halt_ack from next cycle for 5 cycles, stall_cnt +5; halt with concurrent
//    mispredict -> redirect serviced, HALT entered one cycle later.
//  5 CNT_W=4, 20 mispredicts -> mispred_cnt holds 15.
//  6 assert rst low during HALT with counters nonzero -> halt_ack=0, counters 0, BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_flow_ctrl.sv
// Fetch/decode front-end sequencer: post-reset boot hold, mispredict redirect, load-use
// bubbles, halt/resume handshake and saturating mispredict/stall performance counters.
module fetch_flow_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Eval_branchE,
    input  logic             PCSrcE,
    input  logic             Predict_branchE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      PCPlus4E,
    input  logic             lu_hazardD,
    input  logic             halt_req,
    output logic             halt_ack,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             StateUpdateEnable,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int               BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]    BOOT_LAST = BW'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // With no warm-up requested, reset lands directly in RUN.
    localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    state_t           state_r;
    state_t           state_n;
    logic [BW-1:0]    boot_cnt_r;
    logic [BW-1:0]    boot_cnt_n;
    logic             halt_ack_r;
    logic [CNT_W-1:0] mispred_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             mispredict_s;
    logic             count_en_s;
    logic             stall_f_s;
    logic             stall_d_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic             redirect_valid_s;
    logic             state_update_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_W'(1'b1);
        end
    endfunction

    assign mispredict_s = Eval_branchE & (PCSrcE ^ Predict_branchE);
    assign count_en_s   = (state_r == ST_RUN) || (state_r == ST_HALT);

    // Next-state selection and per-cycle pipeline control decode
    always_comb begin
        state_n          = state_r;
        boot_cnt_n       = boot_cnt_r;
        stall_f_s        = 1'b0;
        stall_d_s        = 1'b0;
        flush_d_s        = 1'b0;
        flush_e_s        = 1'b0;
        redirect_valid_s = 1'b0;
        state_update_s   = 1'b0;

        case (state_r)
            ST_BOOT: begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
                if (boot_cnt_r == BOOT_LAST) begin
                    state_n    = ST_RUN;
                    boot_cnt_n = {BW{1'b0}};
                end else begin
                    boot_cnt_n = boot_cnt_r + BW'(1'b1);
                end
            end

            ST_RUN: begin
                state_update_s = Eval_branchE;
                // A mispredict squashes the hazarding instruction, so it outranks the stall.
                if (mispredict_s) begin
                    redirect_valid_s = 1'b1;
                    flush_d_s        = 1'b1;
                    flush_e_s        = 1'b1;
                end else if (lu_hazardD) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                end else begin
                    flush_e_s = 1'b0;
                end
                if (halt_req && !mispredict_s) begin
                    state_n = ST_HALT;
                end else begin
                    state_n = ST_RUN;
                end
            end

            ST_HALT: begin
                state_update_s   = Eval_branchE;
                stall_f_s        = 1'b1;
                flush_e_s        = 1'b1;
                // The PC register must still capture a redirect from a branch draining out of E.
                stall_d_s        = ~mispredict_s;
                flush_d_s        = mispredict_s;
                redirect_valid_s = mispredict_s;
                if (halt_req) begin
                    state_n = ST_HALT;
                end else begin
                    state_n = ST_RUN;
                end
            end

            default: begin
                state_n    = RESET_STATE;
                boot_cnt_n = {BW{1'b0}};
                stall_f_s  = 1'b1;
                stall_d_s  = 1'b1;
                flush_d_s  = 1'b1;
                flush_e_s  = 1'b1;
            end
        endcase
    end

    // FSM state, boot counter and halt acknowledge registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RESET_STATE;
            boot_cnt_r <= {BW{1'b0}};
            halt_ack_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            boot_cnt_r <= boot_cnt_n;
            halt_ack_r <= (state_n == ST_HALT);
        end
    end

    // Saturating performance counters; boot-time stalls are not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispred_cnt_r <= {CNT_W{1'b0}};
            stall_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (count_en_s && mispredict_s) begin
                mispred_cnt_r <= sat_inc(mispred_cnt_r);
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
            if (count_en_s && stall_f_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign redirect_pc       = PCSrcE ? PCTargetE : PCPlus4E;
    assign halt_ack          = halt_ack_r;
    assign StallF            = stall_f_s;
    assign StallD            = stall_d_s;
    assign FlushD            = flush_d_s;
    assign FlushE            = flush_e_s;
    assign redirect_valid    = redirect_valid_s;
    assign StateUpdateEnable = state_update_s;
    assign mispred_cnt       = mispred_cnt_r;
    assign stall_cnt         = stall_cnt_r;

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Bench for fetch_flow_ctrl: a 16-bit-counter instance with a 4-cycle boot and a 4-bit-counter
// instance with no boot share stimulus and are compared against a cycle-level behavioural model.
module tb_fetch_flow_ctrl;

    localparam int BOOT = 4;
    localparam int MAX1 = 65535;
    localparam int MAX2 = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        eval_b, pcsrc, pred, lu, halt_req;
    logic [31:0] tgt, p4;

    logic        halt_ack, stall_f, stall_d, flush_d, flush_e, rv, sue;
    logic [31:0] rpc;
    logic [15:0] mcnt, scnt;
    logic        halt_ack2, stall_f2, stall_d2, flush_d2, flush_e2, rv2, sue2;
    logic [31:0] rpc2;
    logic [3:0]  mcnt2, scnt2;
    logic [6:0]  ctl1, ctl2;

    int checks = 0;
    int failures = 0;

    // Model state: boot cycles still to run, halted flag, event counts
    int m_boot, m_mis, m_stl, m2_mis, m2_stl;
    bit m_halt, m2_halt;

    always #5 clk = ~clk;

    assign ctl1 = {halt_ack, stall_f, stall_d, flush_d, flush_e, rv, sue};
    assign ctl2 = {halt_ack2, stall_f2, stall_d2, flush_d2, flush_e2, rv2, sue2};

    fetch_flow_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Eval_branchE(eval_b), .PCSrcE(pcsrc), .Predict_branchE(pred),
        .PCTargetE(tgt), .PCPlus4E(p4), .lu_hazardD(lu), .halt_req(halt_req),
        .halt_ack(halt_ack), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .FlushE(flush_e),
        .redirect_valid(rv), .redirect_pc(rpc), .StateUpdateEnable(sue),
        .mispred_cnt(mcnt), .stall_cnt(scnt));

    fetch_flow_ctrl #(.BOOT_CYCLES(0), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .Eval_branchE(eval_b), .PCSrcE(pcsrc), .Predict_branchE(pred),
        .PCTargetE(tgt), .PCPlus4E(p4), .lu_hazardD(lu), .halt_req(halt_req),
        .halt_ack(halt_ack2), .StallF(stall_f2), .StallD(stall_d2), .FlushD(flush_d2), .FlushE(flush_e2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .StateUpdateEnable(sue2),
        .mispred_cnt(mcnt2), .stall_cnt(scnt2));

    // Expected {halt_ack, StallF, StallD, FlushD, FlushE, redirect_valid, StateUpdateEnable}
    function automatic logic [6:0] model_ctl(input int boot_left, input bit halted);
        bit mp;
        mp = eval_b && (pcsrc != pred);
        if (boot_left > 0) return 7'b0111100;
        if (halted)        return {1'b1, 1'b1, !mp, mp, 1'b1, mp, eval_b};
        if (mp)            return {5'b00011, 1'b1, eval_b};
        if (lu)            return {5'b01101, 1'b0, eval_b};
        return {6'b000000, eval_b};
    endfunction

    task automatic model_reset();
        m_boot = BOOT; m_halt = 1'b0; m_mis = 0; m_stl = 0;
        m2_halt = 1'b0; m2_mis = 0; m2_stl = 0;
    endtask

    task automatic model_step();
        bit mp;
        logic [6:0] c;
        mp = eval_b && (pcsrc != pred);
        c = model_ctl(m_boot, m_halt);
        if (m_boot > 0) begin
            m_boot = m_boot - 1;
        end else begin
            if (mp && m_mis < MAX1) m_mis = m_mis + 1;
            if (c[5] && m_stl < MAX1) m_stl = m_stl + 1;
            m_halt = m_halt ? halt_req : (halt_req && !mp);
        end
        c = model_ctl(0, m2_halt);
        if (mp && m2_mis < MAX2) m2_mis = m2_mis + 1;
        if (c[5] && m2_stl < MAX2) m2_stl = m2_stl + 1;
        m2_halt = m2_halt ? halt_req : (halt_req && !mp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic set_idle();
        eval_b = 1'b0; pcsrc = 1'b0; pred = 1'b0; lu = 1'b0; halt_req = 1'b0;
        tgt = $urandom; p4 = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b0111100 || mcnt !== 16'd0 || scnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_hold ctl=%b cnt=%0d/%0d required ctl=0111100 cnt=0/0", ctl1, mcnt, scnt);
        end
        checks++;
        if (ctl2 !== 7'b0000000 || mcnt2 !== 4'd0 || scnt2 !== 4'd0) begin
            failures++;
            $display("FAIL reset_small ctl=%b cnt=%0d/%0d required ctl=0000000 cnt=0/0", ctl2, mcnt2, scnt2);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < BOOT; i++) begin
            eval_b = 1'b1; pcsrc = 1'($urandom_range(0, 1)); pred = ~pcsrc; lu = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (ctl1 !== 7'b0111100) begin
                failures++;
                $display("FAIL boot_cycle%0d ctl=%b required 0111100", i, ctl1);
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_f !== 1'b0 || ctl1 !== 7'b0000000 || scnt !== 16'd0 || mcnt !== 16'd0) begin
            failures++;
            $display("FAIL boot_exit ctl=%b stall_cnt=%0d mispred_cnt=%0d required ctl=0 counts 0", ctl1, scnt, mcnt);
        end
        tick();
    endtask

    task automatic test_mispredict();
        eval_b = 1'b1; pcsrc = 1'b1; pred = 1'b0; tgt = 32'h0000_0100; p4 = 32'h0000_0044;
        @(negedge clk);
        checks++;
        if (rv !== 1'b1 || rpc !== 32'h100 || flush_d !== 1'b1 || flush_e !== 1'b1 || stall_f !== 1'b0) begin
            failures++;
            $display("FAIL mp_taken rv=%b pc=%h fd=%b fe=%b sf=%b required 1 00000100 1 1 0", rv, rpc, flush_d, flush_e, stall_f);
        end
        tick();
        pcsrc = 1'b0; pred = 1'b1; p4 = 32'h0000_0048; tgt = 32'h0000_0200;
        @(negedge clk);
        checks++;
        if (mcnt !== 16'd1) begin
            failures++;
            $display("FAIL mp_count1 mispred_cnt=%0d required 1", mcnt);
        end
        checks++;
        if (rv !== 1'b1 || rpc !== 32'h48) begin
            failures++;
            $display("FAIL mp_nottaken rv=%b pc=%h required 1 00000048", rv, rpc);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (rv !== 1'b0 || mcnt !== 16'd2) begin
            failures++;
            $display("FAIL mp_count2 rv=%b mispred_cnt=%0d required 0 2", rv, mcnt);
        end
        tick();
    endtask

    task automatic test_hazard();
        int s0;
        s0 = m_stl;
        eval_b = 1'b1; pcsrc = 1'b1; pred = 1'b0; lu = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b0001111) begin
            failures++;
            $display("FAIL mp_plus_lu ctl=%b required 0001111", ctl1);
        end
        tick();
        eval_b = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b0110100) begin
            failures++;
            $display("FAIL lu_only ctl=%b required 0110100", ctl1);
        end
        tick();
        eval_b = 1'b1; pcsrc = 1'b1; pred = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b0110101 || scnt !== 16'(s0 + 1)) begin
            failures++;
            $display("FAIL lu_correct_branch ctl=%b stall_cnt=%0d required 0110101 %0d", ctl1, scnt, s0 + 1);
        end
        tick();
        set_idle();
    endtask

    task automatic test_halt();
        int s0;
        s0 = m_stl;
        halt_req = 1'b1;
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b0 || stall_f !== 1'b0) begin
            failures++;
            $display("FAIL halt_req_cycle ack=%b sf=%b required 0 0", halt_ack, stall_f);
        end
        tick();
        for (int i = 1; i <= 5; i++) begin
            halt_req = (i < 5);
            @(negedge clk);
            checks++;
            if (ctl1 !== 7'b1110100) begin
                failures++;
                $display("FAIL halt_cycle%0d ctl=%b required 1110100", i, ctl1);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b0 || stall_f !== 1'b0 || scnt !== 16'(s0 + 5)) begin
            failures++;
            $display("FAIL halt_exit ack=%b sf=%b stall_cnt=%0d required 0 0 %0d", halt_ack, stall_f, scnt, s0 + 5);
        end
        tick();
        halt_req = 1'b1; eval_b = 1'b1; pcsrc = 1'b1; pred = 1'b0;
        @(negedge clk);
        checks++;
        if (rv !== 1'b1 || halt_ack !== 1'b0 || rpc !== tgt) begin
            failures++;
            $display("FAIL halt_mp_redirect rv=%b ack=%b pc=%h required 1 0 %h", rv, halt_ack, rpc, tgt);
        end
        tick();
        eval_b = 1'b0;
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b0) begin
            failures++;
            $display("FAIL halt_deferred ack=%b required 0", halt_ack);
        end
        tick();
        eval_b = 1'b1; pcsrc = 1'b0; pred = 1'b1; p4 = $urandom;
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b1101111 || rpc !== p4) begin
            failures++;
            $display("FAIL halt_inner_mp ctl=%b pc=%h required 1101111 %h", ctl1, rpc, p4);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b1) begin
            failures++;
            $display("FAIL halt_drop_cycle ack=%b required 1", halt_ack);
        end
        tick();
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b0) begin
            failures++;
            $display("FAIL halt_resumed ack=%b required 0", halt_ack);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            eval_b = 1'b1; pcsrc = 1'($urandom_range(0, 1)); pred = ~pcsrc; lu = 1'($urandom_range(0, 1));
            tick();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (mcnt2 !== 4'd15 || mcnt !== m_mis[15:0]) begin
            failures++;
            $display("FAIL saturation small=%0d wide=%0d required 15 %0d", mcnt2, mcnt, m_mis);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  exp1, exp2;
        logic [31:0] exp_pc;
        for (int i = 0; i < 400; i++) begin
            eval_b = 1'($urandom_range(0, 1)); pcsrc = 1'($urandom_range(0, 1));
            pred = 1'($urandom_range(0, 1)); lu = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
            tgt = $urandom; p4 = $urandom;
            exp1 = model_ctl(m_boot, m_halt);
            exp2 = model_ctl(0, m2_halt);
            exp_pc = pcsrc ? tgt : p4;
            @(negedge clk);
            checks++;
            if (ctl1 !== exp1) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d ctl=%b required %b", i, ctl1, exp1);
            end
            checks++;
            if (exp1[1] && rpc !== exp_pc) begin
                failures++;
                $display("FAIL rand_pc cyc=%0d pc=%h required %h", i, rpc, exp_pc);
            end
            checks++;
            if (mcnt !== m_mis[15:0] || scnt !== m_stl[15:0]) begin
                failures++;
                $display("FAIL rand_cnt cyc=%0d cnt=%0d/%0d required %0d/%0d", i, mcnt, scnt, m_mis, m_stl);
            end
            checks++;
            if (ctl2 !== exp2 || mcnt2 !== m2_mis[3:0] || scnt2 !== m2_stl[3:0]) begin
                failures++;
                $display("FAIL rand_small cyc=%0d ctl=%b cnt=%0d/%0d required %b %0d/%0d",
                         i, ctl2, mcnt2, scnt2, exp2, m2_mis, m2_stl);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_in_halt();
        set_idle();
        halt_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (halt_ack !== 1'b1 || mcnt === 16'd0 || scnt === 16'd0) begin
            failures++;
            $display("FAIL pre_reset_halt ack=%b cnt=%0d/%0d required 1 and nonzero counts", halt_ack, mcnt, scnt);
        end
        eval_b = 1'b1; pcsrc = 1'b1; pred = 1'b0;
        #1;
        checks++;
        if (rv !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_redirect rv=%b required 1", rv);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (halt_ack !== 1'b0 || mcnt !== 16'd0 || scnt !== 16'd0 || rv !== 1'b0 || stall_f !== 1'b1) begin
            failures++;
            $display("FAIL async_reset ack=%b cnt=%0d/%0d rv=%b sf=%b required 0 0/0 0 1",
                     halt_ack, mcnt, scnt, rv, stall_f);
        end
        model_reset();
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < BOOT; i++) begin
            @(negedge clk);
            checks++;
            if (ctl1 !== 7'b0111100) begin
                failures++;
                $display("FAIL reboot_cycle%0d ctl=%b required 0111100", i, ctl1);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (ctl1 !== 7'b0000000 || scnt !== 16'd0 || mcnt !== 16'd0) begin
            failures++;
            $display("FAIL reboot_exit ctl=%b cnt=%0d/%0d required 0000000 0/0", ctl1, mcnt, scnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_hazard();
        test_halt();
        test_saturation();
        test_random();
        test_reset_in_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
